hailstone_engine: RTL and testbench

Parametrised hardware Collatz (hailstone) sequence engine: accepts a start value, emits each term of the sequence one per clock, and reports step count, peak value and termination status. It is the hardware successor to the MCPU hailstone test program: it runs the same even/odd iteration without software loop overhead, at configurable width, with overflow and step-limit detection. It is used as an MCPU-side accelerator and as a golden-reference stream generator for CPU program checks.

---
 rtl/hailstone_pkg.sv | 14 +
 rtl/hailstone_next.sv | 26 ++
 rtl/hailstone_engine.sv | 136 +++++++++++++
 tb/tb_hailstone_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hailstone_pkg.sv
// Shared types and status codes for the hailstone (Collatz) sequence engine.
package hailstone_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;

   localparam logic [1:0] ERR_OK    = 2'd0;
   localparam logic [1:0] ERR_ZERO  = 2'd1;
   localparam logic [1:0] ERR_OVF   = 2'd2;
   localparam logic [1:0] ERR_LIMIT = 2'd3;

endpackage

// File: rtl/hailstone_next.sv
// Combinational next-term generator: n/2 for even n, 3n+1 for odd n, plus overflow flag.
module hailstone_next #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] n_i,
   output logic [WIDTH-1:0] next_o,
   output logic             ovf_o
);

   // 3n+1 needs two guard bits: (2^W-1)*3+1 < 2^(W+2).
   logic [WIDTH+1:0] wide;
   logic [WIDTH+1:0] tripled;

   // Select halving or 3n+1; overflow only possible on the odd path.
   always_comb begin
      wide    = {2'b00, n_i};
      tripled = (wide << 1) + wide + (WIDTH+2)'(1);
      next_o  = n_i >> 1;
      ovf_o   = 1'b0;
      if (n_i[0]) begin
         next_o = tripled[WIDTH-1:0];
         ovf_o  = |tripled[WIDTH+1:WIDTH];
      end
   end

endmodule

// File: rtl/hailstone_engine.sv
// Collatz sequence engine: accepts a start value, emits one term per clock and reports
// step count, peak term and termination status.
module hailstone_engine
   import hailstone_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned CNT_WIDTH = 16,
   parameter int unsigned MAX_STEPS = 1000
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [WIDTH-1:0]     n_in_i,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 term_valid_o,
   output logic [WIDTH-1:0]     term_out_o,
   output logic                 done_o,
   output logic [CNT_WIDTH-1:0] steps_o,
   output logic [WIDTH-1:0]     peak_o,
   output logic                 err_o,
   output logic [1:0]           err_code_o
);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     term_q, term_d;
   logic [WIDTH-1:0]     peak_q, peak_d;
   logic [CNT_WIDTH-1:0] steps_q, steps_d;
   logic                 term_valid_q, term_valid_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [1:0]           err_code_q, err_code_d;

   logic [WIDTH-1:0]     next_term;
   logic                 next_ovf;

   hailstone_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .n_i    (term_q),
      .next_o (next_term),
      .ovf_o  (next_ovf)
   );

   // State and result registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         term_q       <= '0;
         peak_q       <= '0;
         steps_q      <= '0;
         term_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= ERR_OK;
      end else begin
         state_q      <= state_d;
         term_q       <= term_d;
         peak_q       <= peak_d;
         steps_q      <= steps_d;
         term_valid_q <= term_valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
      end
   end

   // Next-state logic; results hold by default, done/term_valid are single-cycle strobes.
   always_comb begin
      state_d      = state_q;
      term_d       = term_q;
      peak_d       = peak_q;
      steps_d      = steps_q;
      err_d        = err_q;
      err_code_d   = err_code_q;
      term_valid_d = 1'b0;
      done_d       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               term_d     = n_in_i;
               peak_d     = n_in_i;
               steps_d    = '0;
               err_d      = 1'b0;
               err_code_d = ERR_OK;
               if (n_in_i == '0) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_ZERO;
                  done_d     = 1'b1;
               end else begin
                  term_valid_d = 1'b1;
                  state_d      = StRun;
               end
            end
         end
         StRun: begin
            if (term_q == WIDTH'(1)) begin
               done_d     = 1'b1;
               err_code_d = ERR_OK;
               state_d    = StIdle;
            end else if (steps_q == CNT_WIDTH'(MAX_STEPS)) begin
               done_d     = 1'b1;
               err_d      = 1'b1;
               err_code_d = ERR_LIMIT;
               state_d    = StIdle;
            end else if (next_ovf) begin
               // term_q keeps the last representable term.
               done_d     = 1'b1;
               err_d      = 1'b1;
               err_code_d = ERR_OVF;
               state_d    = StIdle;
            end else begin
               term_d       = next_term;
               steps_d      = steps_q + CNT_WIDTH'(1);
               term_valid_d = 1'b1;
               if (next_term > peak_q) begin
                  peak_d = next_term;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign ready_o      = (state_q == StIdle);
   assign busy_o       = (state_q != StIdle);
   assign term_valid_o = term_valid_q;
   assign term_out_o   = term_q;
   assign done_o       = done_q;
   assign steps_o      = steps_q;
   assign peak_o       = peak_q;
   assign err_o        = err_q;
   assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_hailstone_engine.sv
// Directed bench for hailstone_engine: three instances (16-bit default, 8-bit, step limit 5)
// observed through one output mux.
module tb_hailstone_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start;
   logic [1:0]  sel;
   logic [15:0] n_in;

   logic        r0, b0, tv0, d0, e0;
   logic [15:0] t0, s0, p0;
   logic [1:0]  c0;
   logic        r1, b1, tv1, d1, e1;
   logic [7:0]  t1, p1;
   logic [15:0] s1;
   logic [1:0]  c1;
   logic        r2, b2, tv2, d2, e2;
   logic [15:0] t2, s2, p2;
   logic [1:0]  c2;

   logic        obs_ready, obs_busy, obs_tv, obs_done, obs_err;
   logic [15:0] obs_term, obs_steps, obs_peak;
   logic [1:0]  obs_code;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] got[$];
   int          cyc;

   hailstone_engine #(.WIDTH(16), .CNT_WIDTH(16), .MAX_STEPS(1000)) u_dut16 (
      .clk_i(clk), .reset_i(reset), .start_i(start && (sel == 2'd0)), .n_in_i(n_in),
      .ready_o(r0), .busy_o(b0), .term_valid_o(tv0), .term_out_o(t0), .done_o(d0),
      .steps_o(s0), .peak_o(p0), .err_o(e0), .err_code_o(c0)
   );

   hailstone_engine #(.WIDTH(8), .CNT_WIDTH(16), .MAX_STEPS(1000)) u_dut8 (
      .clk_i(clk), .reset_i(reset), .start_i(start && (sel == 2'd1)), .n_in_i(n_in[7:0]),
      .ready_o(r1), .busy_o(b1), .term_valid_o(tv1), .term_out_o(t1), .done_o(d1),
      .steps_o(s1), .peak_o(p1), .err_o(e1), .err_code_o(c1)
   );

   hailstone_engine #(.WIDTH(16), .CNT_WIDTH(16), .MAX_STEPS(5)) u_dutlim (
      .clk_i(clk), .reset_i(reset), .start_i(start && (sel == 2'd2)), .n_in_i(n_in),
      .ready_o(r2), .busy_o(b2), .term_valid_o(tv2), .term_out_o(t2), .done_o(d2),
      .steps_o(s2), .peak_o(p2), .err_o(e2), .err_code_o(c2)
   );

   // Route the selected instance onto the common observation signals.
   always_comb begin
      obs_ready = r0; obs_busy = b0; obs_tv = tv0; obs_done = d0; obs_err = e0;
      obs_term = t0; obs_steps = s0; obs_peak = p0; obs_code = c0;
      case (sel)
         2'd1: begin
            obs_ready = r1; obs_busy = b1; obs_tv = tv1; obs_done = d1; obs_err = e1;
            obs_term = {8'd0, t1}; obs_steps = s1; obs_peak = {8'd0, p1}; obs_code = c1;
         end
         2'd2: begin
            obs_ready = r2; obs_busy = b2; obs_tv = tv2; obs_done = d2; obs_err = e2;
            obs_term = t2; obs_steps = s2; obs_peak = p2; obs_code = c2;
         end
         default: ;
      endcase
   end

   task automatic accept(input logic [15:0] n);
      start = 1'b1;
      n_in  = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Gather emitted terms until done; cyc counts edges from the call point to done.
   task automatic collect();
      got.delete();
      cyc = 0;
      while (obs_done !== 1'b1 && cyc < 2000) begin
         if (obs_tv === 1'b1) got.push_back(obs_term);
         @(posedge clk); #1;
         cyc++;
      end
      n_tests++;
      if (obs_done !== 1'b1) begin
         n_fail++;
         $display("FAIL collect_timeout: done=%b after %0d cycles, want 1", obs_done, cyc);
      end else if (obs_tv !== 1'b0) begin
         n_fail++;
         $display("FAIL done_with_tv: term_valid=%b in done cycle, want 0", obs_tv);
      end
   endtask

   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         n_tests++;
         if ({obs_ready, obs_busy, obs_tv, obs_done, obs_err, obs_code, obs_term, obs_steps,
              obs_peak} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_state[%0d]: rdy=%b busy=%b tv=%b done=%b err=%b code=%0d term=%0d steps=%0d peak=%0d, want 1 0 0 0 0 0 0 0 0",
                     s, obs_ready, obs_busy, obs_tv, obs_done, obs_err, obs_code, obs_term,
                     obs_steps, obs_peak);
         end
      end
      sel = 2'd0;
   endtask

   task automatic test_seq6();
      int exp6[9] = '{6, 3, 10, 5, 16, 8, 4, 2, 1};
      int bad = 0;
      sel = 2'd0;
      accept(16'd6);
      collect();
      if (got.size() != 9) bad++;
      else for (int i = 0; i < 9; i++) if (int'(got[i]) != exp6[i]) bad++;
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL seq6_terms: %0d terms, first=%0d last=%0d, want 9 terms 6..1", got.size(),
                  (got.size() > 0) ? got[0] : 16'hffff, (got.size() > 0) ? got[$] : 16'hffff);
      end
      n_tests++;
      if (cyc != 9) begin n_fail++; $display("FAIL seq6_latency: done at +%0d, want +9", cyc); end
      n_tests++;
      if ({obs_steps, obs_peak, obs_term, obs_err, obs_code, obs_ready} !==
          {16'd8, 16'd16, 16'd1, 1'b0, 2'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL seq6_result: steps=%0d peak=%0d term=%0d err=%b code=%0d rdy=%b, want 8 16 1 0 0 1",
                  obs_steps, obs_peak, obs_term, obs_err, obs_code, obs_ready);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({obs_done, obs_steps, obs_peak} !== {1'b0, 16'd8, 16'd16}) begin
         n_fail++;
         $display("FAIL seq6_hold: done=%b steps=%0d peak=%0d, want 0 8 16", obs_done, obs_steps,
                  obs_peak);
      end
   endtask

   task automatic test_seq27();
      sel = 2'd0;
      accept(16'd27);
      collect();
      n_tests++;
      if (got.size() != 112 || cyc != 112) begin
         n_fail++;
         $display("FAIL seq27_len: %0d terms, done at +%0d, want 112 and 112", got.size(), cyc);
      end
      n_tests++;
      if ({obs_steps, obs_peak, obs_term, obs_err, obs_code} !==
          {16'd111, 16'd9232, 16'd1, 1'b0, 2'd0}) begin
         n_fail++;
         $display("FAIL seq27_result: steps=%0d peak=%0d term=%0d err=%b code=%0d, want 111 9232 1 0 0",
                  obs_steps, obs_peak, obs_term, obs_err, obs_code);
      end
   endtask

   task automatic test_one();
      sel = 2'd0;
      accept(16'd1);
      collect();
      n_tests++;
      if (got.size() != 1 || cyc != 1 || obs_steps !== 16'd0 || obs_peak !== 16'd1 ||
          obs_err !== 1'b0) begin
         n_fail++;
         $display("FAIL one: terms=%0d done=+%0d steps=%0d peak=%0d err=%b, want 1 +1 0 1 0",
                  got.size(), cyc, obs_steps, obs_peak, obs_err);
      end
   endtask

   task automatic test_zero();
      sel = 2'd0;
      accept(16'd0);
      n_tests++;
      if ({obs_done, obs_tv, obs_err, obs_code, obs_ready, obs_term, obs_steps} !==
          {1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 16'd0, 16'd0}) begin
         n_fail++;
         $display("FAIL zero: done=%b tv=%b err=%b code=%0d rdy=%b term=%0d steps=%0d, want 1 0 1 1 1 0 0",
                  obs_done, obs_tv, obs_err, obs_code, obs_ready, obs_term, obs_steps);
      end
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({obs_done, obs_err, obs_code} !== {1'b0, 1'b1, 2'd1}) begin
         n_fail++;
         $display("FAIL zero_hold: done=%b err=%b code=%0d, want 0 1 1", obs_done, obs_err, obs_code);
      end
      accept(16'd2);
      n_tests++;
      if ({obs_err, obs_code, obs_tv, obs_term} !== {1'b0, 2'd0, 1'b1, 16'd2}) begin
         n_fail++;
         $display("FAIL zero_clear: err=%b code=%0d tv=%b term=%0d, want 0 0 1 2", obs_err, obs_code,
                  obs_tv, obs_term);
      end
      collect();
   endtask

   task automatic test_ovf();
      sel = 2'd1;
      accept(16'd27);
      collect();
      n_tests++;
      if (got.size() != 12 || cyc != 12 || got[$] !== 16'd107) begin
         n_fail++;
         $display("FAIL ovf_terms: %0d terms, done=+%0d, want 12 terms ending 107, done +12",
                  got.size(), cyc);
      end
      n_tests++;
      if ({obs_steps, obs_peak, obs_term, obs_err, obs_code} !==
          {16'd11, 16'd214, 16'd107, 1'b1, 2'd2}) begin
         n_fail++;
         $display("FAIL ovf_result: steps=%0d peak=%0d term=%0d err=%b code=%0d, want 11 214 107 1 2",
                  obs_steps, obs_peak, obs_term, obs_err, obs_code);
      end
   endtask

   task automatic test_limit();
      sel = 2'd2;
      accept(16'd6);
      collect();
      n_tests++;
      if (got.size() != 6 || cyc != 6 || got[$] !== 16'd8) begin
         n_fail++;
         $display("FAIL limit_terms: %0d terms, done=+%0d, want 6 terms ending 8, done +6",
                  got.size(), cyc);
      end
      n_tests++;
      if ({obs_steps, obs_peak, obs_term, obs_err, obs_code} !==
          {16'd5, 16'd16, 16'd8, 1'b1, 2'd3}) begin
         n_fail++;
         $display("FAIL limit_result: steps=%0d peak=%0d term=%0d err=%b code=%0d, want 5 16 8 1 3",
                  obs_steps, obs_peak, obs_term, obs_err, obs_code);
      end
   endtask

   task automatic test_ignore_start();
      sel = 2'd0;
      accept(16'd6);
      start = 1'b1;
      n_in  = 16'd100;
      @(posedge clk); #1;
      n_tests++;
      if ({obs_term, obs_busy} !== {16'd3, 1'b1}) begin
         n_fail++;
         $display("FAIL ignore_a: term=%0d busy=%b, want 3 1", obs_term, obs_busy);
      end
      @(posedge clk); #1;
      start = 1'b0;
      n_tests++;
      if (obs_term !== 16'd10) begin
         n_fail++;
         $display("FAIL ignore_b: term=%0d, want 10", obs_term);
      end
      collect();
      n_tests++;
      if (got.size() != 7 || cyc != 7 || obs_steps !== 16'd8 || obs_peak !== 16'd16) begin
         n_fail++;
         $display("FAIL ignore_rest: terms=%0d done=+%0d steps=%0d peak=%0d, want 7 +7 8 16",
                  got.size(), cyc, obs_steps, obs_peak);
      end
   endtask

   task automatic test_reset_mid();
      sel = 2'd0;
      accept(16'd27);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if ({obs_ready, obs_busy, obs_tv, obs_done, obs_err, obs_code, obs_term, obs_steps,
           obs_peak} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_mid: rdy=%b busy=%b tv=%b done=%b err=%b code=%0d term=%0d steps=%0d peak=%0d, want 1 0 0 0 0 0 0 0 0",
                  obs_ready, obs_busy, obs_tv, obs_done, obs_err, obs_code, obs_term, obs_steps,
                  obs_peak);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if ({obs_done, obs_ready, obs_tv} !== {1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_mid_after: done=%b rdy=%b tv=%b, want 0 1 0", obs_done, obs_ready,
                  obs_tv);
      end
   endtask

   task automatic test_back_to_back();
      sel = 2'd0;
      accept(16'd6);
      collect();
      // Start raised in the done cycle is taken on the following edge.
      accept(16'd5);
      n_tests++;
      if ({obs_tv, obs_term, obs_steps, obs_peak, obs_done, obs_busy} !==
          {1'b1, 16'd5, 16'd0, 16'd5, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_accept: tv=%b term=%0d steps=%0d peak=%0d done=%b busy=%b, want 1 5 0 5 0 1",
                  obs_tv, obs_term, obs_steps, obs_peak, obs_done, obs_busy);
      end
      collect();
      n_tests++;
      if (got.size() != 6 || cyc != 6 || obs_steps !== 16'd5 || obs_peak !== 16'd16) begin
         n_fail++;
         $display("FAIL b2b_seq: terms=%0d done=+%0d steps=%0d peak=%0d, want 6 +6 5 16",
                  got.size(), cyc, obs_steps, obs_peak);
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      sel   = 2'd0;
      n_in  = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      @(posedge clk); #1;
      test_seq6();
      test_seq27();
      test_one();
      test_zero();
      test_ovf();
      test_limit();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
